lp1_decim: RTL and testbench
============================

Name: lp1_decim

Overview:
- Downstream consumer of the interleaved I/Q output of the lp1 complex low-pass.
- Splits the time-multiplexed y stream into I and Q. Averages 2^log2n consecutive pairs (boxcar plus decimate).
- Presents the saturated averages in parallel with a one-cycle strobe for slow readout and logging.
- Tracks I/Q phase and flags any break in the iq alternation.

Parameters:
- DW, 20, input sample width; matches lp1 y.
- OW, 18, output width of i_out/q_out.
- L2N_MAX, 8, maximum log2 of the decimation factor; accumulator width is DW+L2N_MAX.

Ports:
- clk  in  1  system clock; one sample per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- iq  in  1  lp1 phase flag; y is I (real) when iq=1 and Q (imag) when iq=0.
- y  in  DW  signed interleaved sample from lp1.
- enable  in  1  0 clears and holds the block in SYNC.
- log2n  in  4  decimation exponent 0..L2N_MAX; larger values clamp to L2N_MAX.
- clr_flags  in  1  synchronous clear of the sticky flags.
- i_out  out  OW  signed averaged I.
- q_out  out  OW  signed averaged Q.
- strobe  out  1  one-cycle pulse; i_out/q_out are new.
- sat  out  1  sticky: an output was saturated.
- iq_err  out  1  sticky: iq failed to alternate.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, accumulators 0, pair counter 0, state SYNC.
- States: SYNC, ACC_I, ACC_Q.
- SYNC: wait for enable=1 and iq=1.
  - On that cycle, capture y into acc_i (load, not add).
  - Latch n_cur = clamp(log2n), set pair count 0, go to ACC_Q.
- ACC_Q: expect iq=0.
  - acc_q += y (load on the first pair of a block).
  - If count == 2^n_cur - 1: finish the block and go to ACC_I.
  - Otherwise count++ and go to ACC_I.
- ACC_I: expect iq=1; acc_i += y (load if a block just finished); go to ACC_Q.
- log2n is sampled only at the first I sample of a block; mid-block changes take effect next block.
- Block finish: the cycle after the last Q sample is registered:
  - strobe=1 for exactly one cycle.
  - i_out = sat_OW(acc_i >>> n_cur), q_out = sat_OW(acc_q' >>> n_cur), where acc_q' includes the final Q sample.
  - Arithmetic shift, i.e. floor, no rounding.
  - Latency: last Q in at edge k, strobe/outputs valid after edge k+1.
- Back-to-back blocks: the I sample arriving the same cycle a block finishes starts the next block. No samples are dropped.
- Saturation: result > 2^(OW-1)-1 gives max; < -2^(OW-1) gives min; either case sets sat. Each component is saturated independently.
- Phase error: iq equal on two consecutive cycles while in ACC_I or ACC_Q.
  - Set iq_err, discard the partial block, no strobe, go to SYNC.
  - The offending sample, if iq=1, does not restart the block; the next iq=1 does.
- enable=0: state goes to SYNC next cycle, partial block discarded, strobe 0. i_out/q_out and flags hold.
- clr_flags coinciding with a new sat/iq_err event: the event wins (flag ends 1).
- i_out/q_out hold between strobes.
- Accumulators never overflow: 2^L2N_MAX · 2^(DW-1) fits in DW+L2N_MAX bits.

Decomposition:
- Shared package lp1_pkg: DW, OW, L2N_MAX, accumulator width (DW+L2N_MAX), state encoding constants.
- One sub-module, sat_shift: combinational arithmetic shift by n plus saturation to OW with an overflow flag. Instantiated twice (I and Q), followed by a shared output register.

Test Plan:
1. log2n=0; pairs I=1000, Q=-500 repeated → strobe every 2nd cycle, i_out=1000, q_out=-500, sat=0.
2. log2n=3; 8 pairs with I=7,0,7,0,7,0,7,0 and Q all -1 → one strobe after 16 samples, i_out=floor(28/8)=3, q_out=floor(-8/8)=-1. Then 7 pairs of I=-1 plus one of I=0 → i_out=-1 (floor of -7/8).
3. log2n=2; I=200000, Q=-200000 constant → i_out=131071, q_out=-131072, sat=1. clr_flags pulse → sat=0 until the next block re-saturates.
4. iq held at 1 for two cycles mid-block (log2n=2) → no strobe for that block, iq_err=1. The next clean 4 pairs produce a correct strobe.
5. rst_n asserted mid-block, asynchronously between edges → all outputs 0 immediately. After release, the first strobe follows a full fresh 2^log2n pairs.
6. log2n changed 1→4 in the middle of a block → the current block finishes with 2 pairs/shift 1; the next block uses 16 pairs/shift 4. Values above 8 behave as 8.

Source files
------------

// File: rtl/lp1_pkg.sv
// Shared constants, state encoding and helpers for the lp1 decimator.
package lp1_pkg;

    localparam int P_DW      = 20;             // input sample width (lp1 y)
    localparam int P_OW      = 18;             // averaged output width
    localparam int P_L2N_MAX = 8;              // largest decimation exponent
    localparam int P_AW      = P_DW + P_L2N_MAX; // accumulator width, cannot overflow

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_ACC_I = 2'd1,
        ST_ACC_Q = 2'd2
    } state_t;

    // Limit a requested decimation exponent to the supported maximum.
    function automatic logic [3:0] clamp_l2n(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/lp1_decim_sat_shift.sv
// Arithmetic right shift (floor) followed by saturation to OW bits.
module sat_shift #(
    parameter int IW = 28,
    parameter int OW = 18
) (
    input  logic [IW-1:0] din,
    input  logic [3:0]    n,
    output logic [OW-1:0] dout,
    output logic          ovf
);

    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW-1:0] din_s;
    logic signed [IW-1:0] shifted;

    // Shift toward minus infinity, then clip to the representable output range.
    always_comb begin
        din_s   = din;
        shifted = din_s >>> n;
        ovf     = 1'b0;
        dout    = shifted[OW-1:0];
        if (shifted > MAXV) begin
            dout = MAXV[OW-1:0];
            ovf  = 1'b1;
        end else if (shifted < MINV) begin
            dout = MINV[OW-1:0];
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/lp1_decim.sv
// De-interleaves lp1 I/Q samples, boxcar-averages 2^n pairs and presents the
// saturated averages with a one-cycle strobe. Tracks I/Q phase alternation.
module lp1_decim
    import lp1_pkg::*;
#(
    parameter int DW      = P_DW,
    parameter int OW      = P_OW,
    parameter int L2N_MAX = P_L2N_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iq,
    input  logic [DW-1:0] y,
    input  logic          enable,
    input  logic [3:0]    log2n,
    input  logic          clr_flags,
    output logic [OW-1:0] i_out,
    output logic [OW-1:0] q_out,
    output logic          strobe,
    output logic          sat,
    output logic          iq_err
);

    localparam int AW = DW + L2N_MAX;
    localparam logic [L2N_MAX:0] CNT_ONE = 1;
    localparam logic [3:0]       N_MAX   = 4'(L2N_MAX);

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_i_q, acc_i_d;
    logic [AW-1:0]      acc_q_q, acc_q_d;
    logic [L2N_MAX:0]   cnt_q, cnt_d;
    logic [3:0]         n_cur_q, n_cur_d;
    logic               done_q, done_d;
    logic [OW-1:0]      i_out_q, i_out_d;
    logic [OW-1:0]      q_out_q, q_out_d;
    logic               strobe_q, strobe_d;
    logic               sat_q, sat_d;
    logic               iq_err_q, iq_err_d;

    logic [AW-1:0]      y_ext;
    logic [L2N_MAX:0]   last_cnt;
    logic               blk_last;
    logic               start, take_i, take_q, phase_err;
    logic [OW-1:0]      sat_i_val, sat_q_val;
    logic               ovf_i, ovf_q;

    assign y_ext    = {{L2N_MAX{y[DW-1]}}, y};
    assign last_cnt = (CNT_ONE << n_cur_q) - CNT_ONE;
    assign blk_last = (cnt_q == last_cnt);

    // State register and all datapath registers; every flop clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            cnt_q    <= '0;
            n_cur_q  <= '0;
            done_q   <= 1'b0;
            i_out_q  <= '0;
            q_out_q  <= '0;
            strobe_q <= 1'b0;
            sat_q    <= 1'b0;
            iq_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            cnt_q    <= cnt_d;
            n_cur_q  <= n_cur_d;
            done_q   <= done_d;
            i_out_q  <= i_out_d;
            q_out_q  <= q_out_d;
            strobe_q <= strobe_d;
            sat_q    <= sat_d;
            iq_err_q <= iq_err_d;
        end
    end

    // Classify the incoming sample against the phase the FSM expects.
    always_comb begin
        start     = 1'b0;
        take_i    = 1'b0;
        take_q    = 1'b0;
        phase_err = 1'b0;
        unique case (state_q)
            ST_SYNC:  start = enable & iq;
            ST_ACC_I: if (enable) begin
                          take_i    = iq;
                          phase_err = ~iq;
                      end
            ST_ACC_Q: if (enable) begin
                          take_q    = ~iq;
                          phase_err = iq;
                      end
            default: ;
        endcase
    end

    // Next state: a wrong phase or enable=0 drops back to SYNC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SYNC:  if (start) state_d = ST_ACC_Q;
            ST_ACC_I: state_d = take_i ? ST_ACC_Q : ST_SYNC;
            ST_ACC_Q: state_d = take_q ? ST_ACC_I : ST_SYNC;
            default:  state_d = ST_SYNC;
        endcase
    end

    // Accumulate pairs; cnt==0 marks the first sample of a block (load, not add).
    always_comb begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        n_cur_d = n_cur_q;
        done_d  = 1'b0;
        if (start) begin
            acc_i_d = y_ext;
            n_cur_d = clamp_l2n(log2n, N_MAX);
            cnt_d   = '0;
        end
        if (take_i) begin
            if (cnt_q == '0) begin
                acc_i_d = y_ext;
                n_cur_d = clamp_l2n(log2n, N_MAX);
            end else begin
                acc_i_d = acc_i_q + y_ext;
            end
        end
        if (take_q) begin
            acc_q_d = (cnt_q == '0) ? y_ext : acc_q_q + y_ext;
            if (blk_last) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    sat_shift #(.IW(AW), .OW(OW)) u_sat_i (
        .din  (acc_i_q),
        .n    (n_cur_q),
        .dout (sat_i_val),
        .ovf  (ovf_i)
    );

    sat_shift #(.IW(AW), .OW(OW)) u_sat_q (
        .din  (acc_q_q),
        .n    (n_cur_q),
        .dout (sat_q_val),
        .ovf  (ovf_q)
    );

    // Output register: a completed block is published one cycle after its last Q;
    // new flag events take priority over clr_flags.
    always_comb begin
        i_out_d  = i_out_q;
        q_out_d  = q_out_q;
        strobe_d = done_q;
        if (done_q) begin
            i_out_d = sat_i_val;
            q_out_d = sat_q_val;
        end
        sat_d    = (sat_q & ~clr_flags) | (done_q & (ovf_i | ovf_q));
        iq_err_d = (iq_err_q & ~clr_flags) | phase_err;
    end

    assign i_out  = i_out_q;
    assign q_out  = q_out_q;
    assign strobe = strobe_q;
    assign sat    = sat_q;
    assign iq_err = iq_err_q;

endmodule

// File: tb/tb_lp1_decim.sv
// Directed bench for lp1_decim with a strobe-driven scoreboard.
module tb_lp1_decim;

    logic               clk;
    logic               rst_n;
    logic               iq;
    logic [19:0]        y;
    logic               enable;
    logic [3:0]         log2n;
    logic               clr_flags;
    logic [17:0]        i_out;
    logic [17:0]        q_out;
    logic               strobe;
    logic               sat;
    logic               iq_err;

    typedef struct {
        int i;
        int q;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    lp1_decim dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iq        (iq),
        .y         (y),
        .enable    (enable),
        .log2n     (log2n),
        .clr_flags (clr_flags),
        .i_out     (i_out),
        .q_out     (q_out),
        .strobe    (strobe),
        .sat       (sat),
        .iq_err    (iq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic send(input logic iqv, input int yv);
        iq = iqv;
        y  = yv[19:0];
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int iv, input int qv);
        send(1'b1, iv);
        send(1'b0, qv);
    endtask

    // Let a just-finished block publish, then park the DUT in SYNC.
    task automatic flush();
        send(1'b1, 0);
        enable = 1'b0;
        send(1'b0, 0);
        send(1'b0, 0);
        enable = 1'b1;
    endtask

    task automatic expect_blk(input int iv, input int qv);
        exp_t e;
        e.i = iv;
        e.q = qv;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got i=%0d q=%0d, expected no strobe",
                         $signed(i_out), $signed(q_out));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("i_out", int'($signed(i_out)), e.i);
                chk("q_out", int'($signed(q_out)), e.q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        iq        = 1'b0;
        y         = '0;
        enable    = 1'b0;
        log2n     = 4'd0;
        clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_out",  int'(i_out),  0);
        chk("rst_q_out",  int'(q_out),  0);
        chk("rst_strobe", int'(strobe), 0);
        chk("rst_sat",    int'(sat),    0);
        chk("rst_iq_err", int'(iq_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: no decimation
        enable = 1'b1;
        log2n  = 4'd0;
        for (int k = 0; k < 4; k++) begin
            expect_blk(1000, -500);
            pair(1000, -500);
        end
        flush();
        chk("t1_sat", int'(sat), 0);

        // 2: 8 pairs, floor on positive and negative sums, back-to-back blocks
        log2n = 4'd3;
        expect_blk(3, -1);
        expect_blk(-1, 0);
        for (int k = 0; k < 8; k++) pair((k % 2 == 0) ? 7 : 0, -1);
        for (int k = 0; k < 8; k++) pair((k < 7) ? -1 : 0, 0);
        flush();

        // 3: saturation and clr_flags
        log2n = 4'd2;
        expect_blk(131071, -131072);
        for (int k = 0; k < 4; k++) pair(200000, -200000);
        flush();
        chk("t3_sat_set", int'(sat), 1);
        clr_flags = 1'b1;
        send(1'b0, 0);
        clr_flags = 1'b0;
        chk("t3_sat_clr", int'(sat), 0);
        expect_blk(131071, -131072);
        for (int k = 0; k < 4; k++) pair(200000, -200000);
        chk("t3_sat_still_clr", int'(sat), 0);
        flush();
        chk("t3_sat_reset", int'(sat), 1);

        // 4: phase error mid-block, then a clean block
        enable    = 1'b0;
        clr_flags = 1'b1;
        send(1'b0, 0);
        clr_flags = 1'b0;
        enable    = 1'b1;
        chk("t4_flags_clr", int'(sat | iq_err), 0);
        log2n = 4'd2;
        pair(10, 20);
        send(1'b1, 10);
        send(1'b1, 10);
        chk("t4_iq_err", int'(iq_err), 1);
        expect_blk(4, -4);
        for (int k = 0; k < 4; k++) pair(4, -4);
        flush();
        chk("t4_iq_err_hold", int'(iq_err), 1);
        enable    = 1'b0;
        clr_flags = 1'b1;
        send(1'b0, 0);
        clr_flags = 1'b0;
        enable    = 1'b1;
        chk("t4_iq_err_clr", int'(iq_err), 0);
        pair(1, 1);
        clr_flags = 1'b1;
        send(1'b0, 5);
        clr_flags = 1'b0;
        chk("t4_event_beats_clr", int'(iq_err), 1);

        // 5: asynchronous reset mid-block
        log2n = 4'd1;
        pair(100, 100);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_i_out",  int'(i_out),  0);
        chk("t5_q_out",  int'(q_out),  0);
        chk("t5_iq_err", int'(iq_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_blk(6, -6);
        pair(6, -6);
        pair(6, -6);
        flush();

        // 6: log2n change mid-block, then clamping above 8
        log2n = 4'd1;
        expect_blk(15, 3);
        pair(10, 2);
        log2n = 4'd4;
        pair(20, 4);
        expect_blk(8, -9);
        for (int k = 1; k <= 16; k++) pair(k, -k);
        flush();
        log2n = 4'd15;
        expect_blk(3, -2);
        for (int k = 0; k < 256; k++) pair(3, -2);
        flush();
        chk("t6_sat", int'(sat), 0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_blocks", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
